// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad row scanner with press/release debounce.
// Drives one-hot rows, samples synchronized columns at the end of each row
// dwell, debounces a single pressed key and emits a one-cycle key_valid
// strobe together with the hex key code.
// Optional build macro: KEYPAD_AUTOREPEAT_EN (auto-repeat strobes while held).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | rotating row drive, columns evaluated at end of each dwell
// DB_PRESS | rows frozen, candidate key must stay stable DB_CYCLES cycles
// HELD     | key accepted; waiting DB_CYCLES consecutive all-zero cycles

`timescale 1ns/1ps

module keypad_scanner #(
  parameter int SCAN_DIV      = 4,
  parameter int DB_CYCLES     = 20,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_pressed,
  output logic       key_valid,
  output logic [3:0] key_code
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2
  } state_t;

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DB_W    = $clog2(DB_CYCLES);

  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);

  // Reject parameter values the timing of the scanner cannot support.
  if (SCAN_DIV < 4) begin : g_bad_scan_div
    $error("keypad_scanner: SCAN_DIV must be >= 4");
  end
  if (DB_CYCLES < 2) begin : g_bad_db_cycles
    $error("keypad_scanner: DB_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat_cycles
    $error("keypad_scanner: REPEAT_CYCLES must be >= 2");
  end

  state_t             state;
  logic [1:0]         row_idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DB_W-1:0]    db_cnt;
  logic [1:0]         cap_col;
  logic [3:0]         sync1;
  logic [3:0]         col_s;

  logic               col_onehot;
  logic [1:0]         col_enc;
  logic [3:0]         cap_mask;
  logic               release_done;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] rpt_cnt;
`endif

  function automatic logic [3:0] row_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Row index and column index to the printed keypad legend.
  function automatic logic [3:0] map_key(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h2;
      4'd2:    code = 4'h3;
      4'd3:    code = 4'hA;
      4'd4:    code = 4'h4;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h6;
      4'd7:    code = 4'hB;
      4'd8:    code = 4'h7;
      4'd9:    code = 4'h8;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hC;
      4'd12:   code = 4'hE;
      4'd13:   code = 4'h0;
      4'd14:   code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Two-flop synchronizer for the asynchronous column inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 4'b0000;
      col_s <= 4'b0000;
    end else begin
      sync1 <= cols;
      col_s <= sync1;
    end
  end

  // Single-column detect and encode; multiple columns count as no key.
  always_comb begin
    col_onehot = 1'b0;
    col_enc    = 2'd0;
    case (col_s)
      4'b0001: begin col_onehot = 1'b1; col_enc = 2'd0; end
      4'b0010: begin col_onehot = 1'b1; col_enc = 2'd1; end
      4'b0100: begin col_onehot = 1'b1; col_enc = 2'd2; end
      4'b1000: begin col_onehot = 1'b1; col_enc = 2'd3; end
      default: begin col_onehot = 1'b0; col_enc = 2'd0; end
    endcase
  end

  assign cap_mask     = 4'b0001 << cap_col;
  assign release_done = (col_s == 4'b0000) && (db_cnt == DB_LAST);

  // Scan / debounce / hold sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= SCAN;
      row_idx     <= 2'd0;
      rows        <= 4'b0001;
      dwell_cnt   <= '0;
      db_cnt      <= '0;
      cap_col     <= 2'd0;
      key_pressed <= 1'b0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt     <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (state)
        SCAN: begin
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (col_onehot) begin
              cap_col <= col_enc;
              db_cnt  <= '0;
              state   <= DB_PRESS;
            end else begin
              row_idx <= row_idx + 2'd1;
              rows    <= row_onehot(row_idx + 2'd1);
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end

        DB_PRESS: begin
          if (col_s == cap_mask) begin
            if (db_cnt == DB_LAST) begin
              key_code    <= map_key(row_idx, cap_col);
              key_valid   <= 1'b1;
              key_pressed <= 1'b1;
              db_cnt      <= '0;
              state       <= HELD;
`ifdef KEYPAD_AUTOREPEAT_EN
              rpt_cnt     <= '0;
`endif
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            // Bounce or a different key: abandon and keep scanning.
            db_cnt    <= '0;
            dwell_cnt <= '0;
            row_idx   <= row_idx + 2'd1;
            rows      <= row_onehot(row_idx + 2'd1);
            state     <= SCAN;
          end
        end

        HELD: begin
          // Release counter reuses db_cnt; any nonzero column restarts it.
          if (col_s == 4'b0000) begin
            if (release_done) begin
              key_pressed <= 1'b0;
              db_cnt      <= '0;
              dwell_cnt   <= '0;
              row_idx     <= row_idx + 2'd1;
              rows        <= row_onehot(row_idx + 2'd1);
              state       <= SCAN;
            end else begin
              db_cnt <= db_cnt + 1'b1;
            end
          end else begin
            db_cnt <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          // A release completing this cycle wins over a due repeat.
          if (release_done) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt   <= '0;
            key_valid <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end

        default: begin
          state     <= SCAN;
          dwell_cnt <= '0;
          db_cnt    <= '0;
        end
      endcase
    end
  end

endmodule
